// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the multicycle CPU controller.
//   * opcode constants OP_ADD..OP_JALR (3-bit IR opcode field)
//   * FSM state type and encodings (legacy-compatible localparams)
//   * control-bundle structs shared by the FSM and the ALU-select decoder
// No ports (package).
package cpu_pkg;

  // Instruction opcodes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  // FSM state encoding; codes 5..7 are illegal and recover to FETCH
  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;

  // One-hot-or-zero ALU function select
  typedef struct packed {
    logic sel_add;
    logic sel_nand;
    logic sel_pass1;
    logic sel_eq;
  } alu_sel_t;

  // Non-ALU control strobes produced by the FSM
  typedef struct packed {
    logic imem_req;
    logic ir_load;
    logic dmem_req;
    logic dmem_we;
    logic pc_en;
    logic pc_sel_jalr;
    logic write_en_reg;
    logic wb_sel_mem;
    logic br_take;
  } ctrl_t;

  // True for the two opcodes that visit the MEM state
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mctrl_alu_dec.sv
// mctrl_alu_dec -- combinational ALU-function select for the multicycle
// controller. Only EXEC and MEM drive the ALU; every other phase yields
// all-zero selects, and at most one select is ever high.
// Ports:
//   op_q    in  3  latched opcode
//   phase   in  3  current FSM state
//   alu_sel out 4  {sel_add, sel_nand, sel_pass1, sel_eq}
module mctrl_alu_dec
  import cpu_pkg::*;
(
  input  logic [2:0] op_q,
  input  state_t     phase,
  output alu_sel_t   alu_sel
);

  always_comb begin
    alu_sel = '0;
    if (phase == ST_EXEC) begin
      case (op_q)
        OP_ADD, OP_ADDI, OP_LW, OP_SW: alu_sel.sel_add   = 1'b1;
        OP_NAND:                       alu_sel.sel_nand  = 1'b1;
        OP_LUI, OP_JALR:               alu_sel.sel_pass1 = 1'b1;
        OP_BEQ:                        alu_sel.sel_eq    = 1'b1;
        default:                       alu_sel           = '0;
      endcase
    end else if (phase == ST_MEM) begin
      // Address stays on the adder for the whole memory handshake
      alu_sel.sel_add = is_mem_op(op_q);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- FETCH/DECODE/EXEC/MEM/WB control FSM for a small
// multicycle CPU with request/acknowledge instruction and data memories.
// Build option: define MCTRL_INSTR_CNT_EN to get a 16-bit wrapping
// retired-instruction counter; otherwise retired_cnt is tied to zero.
// Ports:
//   clk, rst (sync, active high)
//   opcode[2:0]   IR opcode, valid from DECODE onward
//   eq_out        ALU equality result (BEQ)
//   imem_req/imem_ack           instruction-fetch handshake
//   dmem_req/dmem_we/dmem_ack   data-memory handshake
//   ir_load, pc_en, pc_sel_jalr, write_en_reg, wb_sel_mem, br_take
//   alu_add, alu_nand, alu_pass1, alu_eq   ALU select (at most one high)
//   state[2:0]    current FSM state
//   retired_cnt[15:0] retired instructions (one per pc_en pulse)
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic        eq_out,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_load,
  output logic        pc_en,
  output logic        pc_sel_jalr,
  output logic        write_en_reg,
  output logic        wb_sel_mem,
  output logic        alu_add,
  output logic        alu_nand,
  output logic        alu_pass1,
  output logic        alu_eq,
  output logic        br_take,
  output logic [2:0]  state,
  output logic [15:0] retired_cnt
);

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] op_q;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;
  alu_sel_t   alu_raw;
  alu_sel_t   alu_sel;

  // ---------------------------------------------------------------
  // Next-state and control decode. Acks are only looked at in the
  // state that owns the handshake, so strays elsewhere are ignored.
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ctrl_raw   = '0;
    case (state_reg)
      ST_FETCH: begin
        ctrl_raw.imem_req = 1'b1;
        if (imem_ack) begin
          ctrl_raw.ir_load = 1'b1;
          state_next       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD, OP_ADDI, OP_NAND, OP_LUI: state_next = ST_WB;
          OP_LW, OP_SW:                     state_next = ST_MEM;
          OP_BEQ: begin
            ctrl_raw.pc_en   = 1'b1;
            ctrl_raw.br_take = eq_out;
            state_next       = ST_FETCH;
          end
          default: begin // OP_JALR
            ctrl_raw.write_en_reg = 1'b1;
            ctrl_raw.pc_sel_jalr  = 1'b1;
            ctrl_raw.pc_en        = 1'b1;
            state_next            = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        ctrl_raw.dmem_req = 1'b1;
        ctrl_raw.dmem_we  = (op_q == OP_SW);
        if (dmem_ack) begin
          // A store retires here; a load still has to write back
          ctrl_raw.pc_en = (op_q == OP_SW);
          state_next     = (op_q == OP_LW) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        ctrl_raw.write_en_reg = 1'b1;
        ctrl_raw.pc_en        = 1'b1;
        ctrl_raw.wb_sel_mem   = (op_q == OP_LW);
        state_next            = ST_FETCH;
      end
      default: begin
        // Illegal encodings: outputs quiet, recover to FETCH
        state_next = ST_FETCH;
      end
    endcase
  end

  mctrl_alu_dec u_alu_dec (
    .op_q    (op_q),
    .phase   (state_reg),
    .alu_sel (alu_raw)
  );

  // While rst is high every strobe is forced low, including the
  // memory requests, so nothing is launched during the reset cycle.
  assign ctrl    = rst ? '0 : ctrl_raw;
  assign alu_sel = rst ? '0 : alu_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
      op_q      <= OP_ADD;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE) begin
        op_q <= opcode;
      end
    end
  end

`ifdef MCTRL_INSTR_CNT_EN
  logic [15:0] cnt_reg;

  // Wraps naturally from 0xFFFF to 0x0000
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (ctrl.pc_en) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign retired_cnt = cnt_reg;
`else
  assign retired_cnt = '0;
`endif

  assign imem_req     = ctrl.imem_req;
  assign ir_load      = ctrl.ir_load;
  assign dmem_req     = ctrl.dmem_req;
  assign dmem_we      = ctrl.dmem_we;
  assign pc_en        = ctrl.pc_en;
  assign pc_sel_jalr  = ctrl.pc_sel_jalr;
  assign write_en_reg = ctrl.write_en_reg;
  assign wb_sel_mem   = ctrl.wb_sel_mem;
  assign br_take      = ctrl.br_take;
  assign alu_add      = alu_sel.sel_add;
  assign alu_nand     = alu_sel.sel_nand;
  assign alu_pass1    = alu_sel.sel_pass1;
  assign alu_eq       = alu_sel.sel_eq;
  assign state        = state_reg;

endmodule
